midi_stream_parser: RTL and testbench

Parametrised successor to the single-message MIDI decoder. It consumes UART receive bytes and fully parses channel-voice messages: 1- and 2-data-byte lengths, running status, per-channel filtering, note-on velocity-0 normalisation, and SysEx/realtime skipping. Completed messages are buffered in a small output FIFO with a valid/ready handshake. It sits between the UART receiver and the synth voice allocator.

---
 rtl/midi_pkg.sv | 35 +++
 rtl/midi_msg_fifo.sv | 60 ++++++
 rtl/midi_stream_parser.sv | 166 ++++++++++++++++
 tb/tb_midi_stream_parser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types, constants and helpers for the MIDI stream parser
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D1    = 2'd1,
        D2    = 2'd2,
        SYSEX = 2'd3
    } state_t;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;

    localparam int MSG_W = 22;

    typedef struct packed {
        logic [7:0] status;
        logic [6:0] data1;
        logic [6:0] data2;
    } msg_t;

    // Program change and channel aftertouch carry one data byte, all others two
    function automatic logic [1:0] msg_len(input logic [3:0] nib);
        return (nib == PROG || nib == CH_AT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// rtl/midi_msg_fifo.sv - first-word-fall-through message FIFO with flush
module midi_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so downstream never sees stale entries
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/midi_stream_parser.sv
// rtl/midi_stream_parser.sv - MIDI channel-voice byte parser feeding a message FIFO
module midi_stream_parser
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int RUNNING_STATUS = 1,
    parameter int NOTE0_AS_OFF   = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        clear,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [15:0] channel_mask,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [7:0]  msg_status,
    output logic [6:0]  msg_data1,
    output logic [6:0]  msg_data2,
    output logic        overflow,
    output logic        start_pulse
);
    state_t     state;
    logic [7:0] run_status;
    logic       rs_valid;
    logic [6:0] d1_q;

    logic       byte_ok;
    logic       is_rt;
    logic       is_sys;
    logic       is_stat;
    logic       is_data;
    logic       len1;
    logic       complete;
    logic [6:0] cmp_d1;
    logic [6:0] cmp_d2;
    logic [7:0] push_status;
    logic       push_req;
    logic       pop;
    logic       space;
    logic       push;
    logic       fifo_full;
    logic       fifo_empty;
    msg_t       push_msg;
    msg_t       head;

    assign byte_ok = en && rx_valid && !clear;
    assign is_rt   = (rx_data[7:3] == 5'b11111);
    assign is_sys  = (rx_data[7:4] == 4'hF) && !is_rt;
    assign is_stat = rx_data[7] && (rx_data[7:4] != 4'hF);
    assign is_data = !rx_data[7];
    assign len1    = (msg_len(run_status[7:4]) == 2'd1);

    // Decide whether the incoming data byte finishes a message this cycle
    always_comb begin
        complete = 1'b0;
        cmp_d1   = d1_q;
        cmp_d2   = '0;
        if (byte_ok && is_data) begin
            case (state)
                IDLE: begin
                    if (RUNNING_STATUS != 0 && rs_valid && len1) begin
                        complete = 1'b1;
                        cmp_d1   = rx_data[6:0];
                    end
                end
                D1: begin
                    if (len1) begin
                        complete = 1'b1;
                        cmp_d1   = rx_data[6:0];
                    end
                end
                D2: begin
                    complete = 1'b1;
                    cmp_d2   = rx_data[6:0];
                end
                default: ;
            endcase
        end
    end

    // Note-on with zero velocity becomes note-off on the same channel
    always_comb begin
        push_status = run_status;
        if (NOTE0_AS_OFF != 0 && run_status[7:4] == NOTE_ON && cmp_d2 == '0) begin
            push_status = {NOTE_OFF, run_status[3:0]};
        end
    end

    assign push_req = complete && channel_mask[run_status[3:0]];
    assign pop      = msg_ready && !fifo_empty && !clear;
    assign space    = !fifo_full || pop;
    assign push     = push_req && space;
    assign push_msg = '{status: push_status, data1: cmp_d1, data2: cmp_d2};

    // Parser state machine with registered overflow and start pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            run_status  <= '0;
            rs_valid    <= 1'b0;
            d1_q        <= '0;
            overflow    <= 1'b0;
            start_pulse <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            rs_valid    <= 1'b0;
            overflow    <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= push && push_status[7:4] == NOTE_ON && cmp_d2 != '0;
            if (push_req && !space) overflow <= 1'b1;
            if (byte_ok) begin
                if (is_stat) begin
                    run_status <= rx_data;
                    rs_valid   <= 1'b1;
                    state      <= D1;
                end else if (is_sys) begin
                    rs_valid <= 1'b0;
                    state    <= (rx_data == SYSEX_START) ? SYSEX : IDLE;
                end else if (is_data) begin
                    case (state)
                        IDLE: begin
                            if (RUNNING_STATUS != 0 && rs_valid && !len1) begin
                                d1_q  <= rx_data[6:0];
                                state <= D2;
                            end
                        end
                        D1: begin
                            if (len1) begin
                                state <= IDLE;
                            end else begin
                                d1_q  <= rx_data[6:0];
                                state <= D2;
                            end
                        end
                        D2:      state <= IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

    midi_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .flush     (clear),
        .push      (push),
        .push_data (push_msg),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign msg_valid  = !fifo_empty;
    assign msg_status = head.status;
    assign msg_data1  = head.data1;
    assign msg_data2  = head.data2;

endmodule

// File: tb/tb_midi_stream_parser.sv
// tb/tb_midi_stream_parser.sv - randomized self-checking bench for midi_stream_parser
module tb_midi_stream_parser;
    localparam int DEPTH = 4;
    localparam int RS    = 1;
    localparam int N0OFF = 1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [15:0] channel_mask = 16'hFFFF;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic [7:0]  msg_status;
    logic [6:0]  msg_data1;
    logic [6:0]  msg_data2;
    logic        overflow;
    logic        start_pulse;

    int errors = 0;
    int checks = 0;

    // Reference model: message queue plus byte-level parsing state
    logic [21:0] mq[$];
    logic [6:0]  m_buf[$];
    logic [7:0]  m_rs = '0;
    bit          m_rs_ok = 0;
    bit          m_pend = 0;
    bit          m_sysex = 0;
    bit          m_ovf = 0;
    bit          m_start = 0;

    midi_stream_parser #(
        .FIFO_DEPTH     (DEPTH),
        .RUNNING_STATUS (RS),
        .NOTE0_AS_OFF   (N0OFF)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .clear        (clear),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .channel_mask (channel_mask),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_status   (msg_status),
        .msg_data1    (msg_data1),
        .msg_data2    (msg_data2),
        .overflow     (overflow),
        .start_pulse  (start_pulse)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit i_en, input bit i_rv, input logic [7:0] b,
                         input bit i_rdy, input bit i_clr);
        bit          have;
        logic [7:0]  s;
        logic [6:0]  d1;
        logic [6:0]  d2;
        int          len;
        have = 0;
        s = '0; d1 = '0; d2 = '0;
        if (i_clr) begin
            mq.delete(); m_buf.delete();
            m_ovf = 0; m_start = 0; m_sysex = 0; m_pend = 0; m_rs_ok = 0;
            return;
        end
        if (i_en && i_rv) begin
            if (b >= 8'hF8) begin
                // realtime: no effect
            end else if (b >= 8'hF0) begin
                m_rs_ok = 0; m_pend = 0; m_buf.delete(); m_sysex = (b == 8'hF0);
            end else if (b >= 8'h80) begin
                m_rs = b; m_rs_ok = 1; m_pend = 1; m_buf.delete(); m_sysex = 0;
            end else if (!m_sysex && (m_pend || (RS != 0 && m_rs_ok))) begin
                m_buf.push_back(b[6:0]);
                m_pend = 1;
                len = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
                if (m_buf.size() == len) begin
                    s  = m_rs;
                    d1 = m_buf[0];
                    d2 = (len == 2) ? m_buf[1] : 7'd0;
                    m_buf.delete();
                    m_pend = 0;
                    if (N0OFF != 0 && s[7:4] == 4'h9 && d2 == 0) s[7:4] = 4'h8;
                    have = channel_mask[m_rs[3:0]];
                end
            end
        end
        if (i_rdy && mq.size() > 0) void'(mq.pop_front());
        m_start = 0;
        if (have) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({s, d1, d2});
                m_start = (s[7:4] == 4'h9 && d2 != 0);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic step(input bit i_en, input bit i_rv, input logic [7:0] b,
                        input bit i_rdy, input bit i_clr);
        logic [21:0] exp_head;
        @(negedge clk);
        exp_head = (mq.size() > 0) ? mq[0] : 22'd0;
        chk("msg_valid", msg_valid, mq.size() > 0);
        chk("head", {msg_status, msg_data1, msg_data2}, exp_head);
        chk("overflow", overflow, m_ovf);
        chk("start_pulse", start_pulse, m_start);
        en = i_en; rx_valid = i_rv; rx_data = b; msg_ready = i_rdy; clear = i_clr;
        model(i_en, i_rv, b, i_rdy, i_clr);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1, 1, b, rdy, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00, rdy, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         cat;
        bit         rdy;
        int         rdy_mod;

        repeat (3) @(negedge clk);
        chk("rst_valid", msg_valid, 0);
        chk("rst_head", {msg_status, msg_data1, msg_data2}, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_start", start_pulse, 0);
        nrst = 1'b1;

        // Basic note-on, FIFO held
        send(8'h90, 0); send(8'h3C, 0); send(8'h64, 0);
        chk("note_on_valid", msg_valid, 1);
        chk("note_on_head", {msg_status, msg_data1, msg_data2}, {8'h90, 7'h3C, 7'h64});
        chk("note_on_pulse", start_pulse, 1);
        idle(2, 1);

        // Running status with velocity-0 normalisation
        send(8'h91, 0); send(8'h40, 0); send(8'h50, 0); send(8'h43, 0); send(8'h00, 0);
        idle(1, 1);
        chk("rs_second_head", {msg_status, msg_data1, msg_data2}, {8'h81, 7'h43, 7'h00});
        idle(2, 1);

        // One-byte messages, realtime inside a message, SysEx skipping
        send(8'hC2, 1); send(8'h05, 1); send(8'h07, 1); idle(2, 1);
        send(8'h90, 1); send(8'h3C, 1); send(8'hF8, 1); send(8'h64, 1); idle(2, 1);
        send(8'hF0, 1); send(8'h7E, 1); send(8'h01, 1); send(8'hF7, 1); send(8'h45, 1);
        chk("sysex_nothing", msg_valid, 0);

        // Channel filter
        channel_mask = 16'h0001;
        send(8'h95, 1); send(8'h3C, 1); send(8'h64, 1);
        chk("mask_valid", msg_valid, 0);
        chk("mask_ovf", overflow, 0);
        channel_mask = 16'hFFFF;

        // Overflow then clear
        for (int i = 0; i <= DEPTH; i++) begin
            send(8'h90, 0); send(8'(8'h30 + i), 0); send(8'h40, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_head", {msg_status, msg_data1, msg_data2}, {8'h90, 7'h30, 7'h40});
        step(1, 0, 8'h00, 1, 1);
        chk("clear_valid", msg_valid, 0);
        chk("clear_ovf", overflow, 0);

        // Randomized traffic against the model
        rdy_mod = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) begin
                channel_mask = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
                rdy_mod = $urandom_range(1, 6);
            end
            cat = $urandom_range(0, 15);
            if (cat <= 3)       b = 8'(8'h80 + $urandom_range(0, 8'h6F));
            else if (cat == 11) b = 8'(8'hF8 + $urandom_range(0, 7));
            else if (cat == 12) b = 8'hF0;
            else if (cat == 13) b = 8'hF7;
            else if (cat == 14) b = 8'(8'hF1 + $urandom_range(0, 5));
            else                b = 8'($urandom_range(0, 8'h7F));
            rdy = ($urandom_range(0, rdy_mod) == 0);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, b, rdy,
                 $urandom_range(0, 199) == 0);
        end
        idle(2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
